// File: rtl/conv_frame_sequencer_if.sv
// AXI-Stream handshake bundle for the convolution frame sequencer: pixel input (s_axis) and result output (m_axis).
// The slave modport is the sequencer's view; the master modport is the environment's view.
interface conv_frame_sequencer_if;
  logic s_axis_tvalid;
  logic s_axis_tready;
  logic s_axis_tlast;
  logic m_axis_tvalid;
  logic m_axis_tready;
  logic m_axis_tlast;

  modport slave (
    input  s_axis_tvalid, s_axis_tlast, m_axis_tready,
    output s_axis_tready, m_axis_tvalid, m_axis_tlast
  );

  modport master (
    output s_axis_tvalid, s_axis_tlast, m_axis_tready,
    input  s_axis_tready, m_axis_tvalid, m_axis_tlast
  );
endinterface

// File: rtl/conv_frame_sequencer.sv
// Frame-level controller for the 3x3 convolution datapath: counts row/col over the frame, drives the global
// pipeline enable, and carries valid/last tokens alongside the fixed-latency datapath to the output stream.
module conv_frame_sequencer #(
  parameter int IMG_W = 128,
  parameter int IMG_H = 128,
  parameter int COL_W = 7,
  parameter int ROW_W = 7,
  parameter int LAT   = 4
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  frame_err,
  output logic                  pipe_en,
  output logic [COL_W-1:0]      lb_addr,
  output logic                  win_valid,
  conv_frame_sequencer_if.slave axis
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

  typedef struct packed {
    logic v;
    logic l;
  } tok_t;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
  localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);

  state_e               state_q, state_d;
  logic [COL_W-1:0]     col_q, col_d;
  logic [ROW_W-1:0]     row_q, row_d;
  logic                 frame_err_q, frame_err_d;
  tok_t [LAT-1:0]       tok_q, tok_d;

  logic adv;
  logic accept;
  logic last_pix;

  // Stall-the-world: everything freezes while a result is held at the output.
  always_comb begin
    adv       = !tok_q[LAT-1].v || axis.m_axis_tready;
    accept    = (state_q == S_RUN) && adv && axis.s_axis_tvalid;
    last_pix  = (row_q == ROW_LAST) && (col_q == COL_LAST);
    win_valid = accept && (row_q >= ROW_TWO) && (col_q >= COL_TWO);
  end

  // NOTE: every variable gets its default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    frame_err_d = frame_err_q;
    tok_d       = tok_q;
    pipe_en     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_RUN;
          col_d       = '0;
          row_d       = '0;
          frame_err_d = 1'b0;
        end
      end
      S_RUN: begin
        pipe_en = accept;
        if (accept) begin
          if (axis.s_axis_tlast != last_pix) frame_err_d = 1'b1;
          if (col_q == COL_LAST) begin
            col_d = '0;
            if (last_pix) state_d = S_DRAIN;
            else          row_d   = row_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        pipe_en = adv;
        if (tok_q[LAT-1].v && tok_q[LAT-1].l && axis.m_axis_tready) state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Drain pushes empty tokens so the remaining results walk out behind the last pixel.
    if (pipe_en) begin
      tok_d[0] = (state_q == S_DRAIN) ? tok_t'('0) : tok_t'{v: win_valid, l: win_valid && last_pix};
      for (int i = 1; i < LAT; i++) tok_d[i] = tok_q[i-1];
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  // NOTE: the token pipe is reset because its valid bits drive m_axis_tvalid; stale tokens would leak out.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q     <= S_IDLE;
      col_q       <= '0;
      row_q       <= '0;
      frame_err_q <= 1'b0;
      tok_q       <= '0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      frame_err_q <= frame_err_d;
      tok_q       <= tok_d;
    end
  end

  assign axis.s_axis_tready = (state_q == S_RUN) && adv;
  assign axis.m_axis_tvalid = tok_q[LAT-1].v;
  assign axis.m_axis_tlast  = tok_q[LAT-1].v && tok_q[LAT-1].l;
  assign busy               = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done               = (state_q == S_DONE);
  assign frame_err          = frame_err_q;
  assign lb_addr            = col_q;

endmodule

// File: tb/tb_conv_frame_sequencer.sv
// Self-checking bench for conv_frame_sequencer on a 5x4 frame with a 2-stage datapath: a pixel-count model
// checks every output each cycle, and directed frames pin beat counts, latency, TLAST, done and frame_err.
module tb_conv_frame_sequencer;
  localparam int W     = 5;
  localparam int H     = 4;
  localparam int LAT   = 2;
  localparam int COL_W = 3;
  localparam int ROW_W = 2;
  localparam int NPIX  = W * H;

  logic             clk = 1'b0;
  logic             areset = 1'b1;
  logic             start = 1'b0;
  logic             busy, done, frame_err, pipe_en, win_valid;
  logic [COL_W-1:0] lb_addr;

  conv_frame_sequencer_if bus ();

  conv_frame_sequencer #(
    .IMG_W(W), .IMG_H(H), .COL_W(COL_W), .ROW_W(ROW_W), .LAT(LAT)
  ) dut (
    .aclk     (clk),
    .areset   (areset),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .frame_err(frame_err),
    .pipe_en  (pipe_en),
    .lb_addr  (lb_addr),
    .win_valid(win_valid),
    .axis     (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: phase 0 idle, 1 run, 2 drain, 3 done; tokens recorded by pipeline-advance number.
  int       ph = 0;
  int       n_acc = 0;
  int       n_adv = 0;
  bit       m_err = 1'b0;
  bit [1:0] hist [int];
  bit       e_mv, e_ml, e_adv, e_srdy, e_acc, e_pe, e_win;
  int       e_row, e_col;

  // Per-frame observations of the DUT, cleared when the model sees a frame start.
  int beats, tlast_cnt, tlast_beat, first_beat_cyc, acc12_cyc, last_hs_cyc, done_cyc;
  int done_cnt, win_cnt, pe_run_cnt;
  bit busy_at_done, busy_at_hs;

  task automatic clear_stats();
    beats = 0; tlast_cnt = 0; tlast_beat = 0; first_beat_cyc = -1; acc12_cyc = -1;
    last_hs_cyc = -1; done_cyc = -1; done_cnt = 0; win_cnt = 0; pe_run_cnt = 0;
    busy_at_done = 1'b1; busy_at_hs = 1'b0;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      e_row = n_acc / W;
      e_col = n_acc % W;
      if (n_adv >= LAT) {e_mv, e_ml} = hist[n_adv-LAT];
      else              {e_mv, e_ml} = 2'b00;
      e_ml   = e_mv && e_ml;
      e_adv  = !e_mv || bus.m_axis_tready;
      e_srdy = (ph == 1) && e_adv;
      e_acc  = e_srdy && bus.s_axis_tvalid;
      e_pe   = (ph == 1) ? e_acc : (ph == 2) ? e_adv : 1'b0;
      e_win  = e_acc && (e_row >= 2) && (e_col >= 2);

      check("m_tvalid",  32'(bus.m_axis_tvalid), 32'(e_mv));
      check("m_tlast",   32'(bus.m_axis_tlast),  32'(e_ml));
      check("s_tready",  32'(bus.s_axis_tready), 32'(e_srdy));
      check("pipe_en",   32'(pipe_en),           32'(e_pe));
      check("win_valid", 32'(win_valid),         32'(e_win));
      check("lb_addr",   32'(lb_addr),           32'(e_col));
      check("busy",      32'(busy),              32'(ph == 1 || ph == 2));
      check("done",      32'(done),              32'(ph == 3));
      check("frame_err", 32'(frame_err),         32'(m_err));

      if (bus.m_axis_tvalid === 1'b1 && bus.m_axis_tready === 1'b1) begin
        beats++;
        if (beats == 1) first_beat_cyc = cyc;
        if (bus.m_axis_tlast === 1'b1) begin
          tlast_cnt++;
          tlast_beat  = beats;
          last_hs_cyc = cyc;
          busy_at_hs  = busy;
        end
      end
      if (done === 1'b1) begin
        done_cnt++;
        done_cyc     = cyc;
        busy_at_done = busy;
      end
      if (win_valid === 1'b1) win_cnt++;
      if (ph == 1 && pipe_en === 1'b1) pe_run_cnt++;
      if (bus.s_axis_tvalid === 1'b1 && bus.s_axis_tready === 1'b1 && n_acc == 12) acc12_cyc = cyc;

      if (areset) begin
        ph = 0; n_acc = 0; n_adv = 0; m_err = 1'b0;
      end else begin
        if (e_pe) begin
          hist[n_adv] = (ph == 2) ? 2'b00 : {e_win, e_win && (n_acc == NPIX-1)};
          n_adv++;
        end
        case (ph)
          0: if (start) begin ph = 1; n_acc = 0; m_err = 1'b0; clear_stats(); end
          1: if (e_acc) begin
               if (bus.s_axis_tlast != (n_acc == NPIX-1)) m_err = 1'b1;
               n_acc++;
               if (n_acc == NPIX) ph = 2;
             end
          2: if (e_mv && e_ml && bus.m_axis_tready) ph = 3;
          default: ph = 0;
        endcase
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " s_tready"},  32'(bus.s_axis_tready), 32'd0);
    check({tag, " m_tvalid"},  32'(bus.m_axis_tvalid), 32'd0);
    check({tag, " m_tlast"},   32'(bus.m_axis_tlast),  32'd0);
    check({tag, " pipe_en"},   32'(pipe_en),           32'd0);
    check({tag, " busy"},      32'(busy),              32'd0);
    check({tag, " done"},      32'(done),              32'd0);
    check({tag, " frame_err"}, 32'(frame_err),         32'd0);
    check({tag, " lb_addr"},   32'(lb_addr),           32'd0);
    check({tag, " win_valid"}, 32'(win_valid),         32'd0);
  endtask

  // Drives one frame (already started) until the DONE cycle, or aborts with areset after abort_after accepts.
  task automatic run_frame(input bit toggle, input bit bad_last, input bit stall, input int abort_after,
                           input bit start_in_run, input bit start_in_done);
    bit   tog = 1'b1;
    bit   stalled = 1'b0;
    bit   finished = 1'b0;
    logic tl;
    for (int c = 0; c < 400 && !finished; c++) begin
      if (ph == 3) begin
        start = start_in_done;
        bus.s_axis_tvalid = 1'b0;
        tick();
        start = 1'b0;
        finished = 1'b1;
      end else if (abort_after > 0 && ph == 1 && n_acc == abort_after) begin
        bus.s_axis_tvalid = 1'b0;
        areset = 1'b1;
        tick();
        areset = 1'b0;
        check_all_zero("abort");
        finished = 1'b1;
      end else begin
        if (stall && !stalled && beats >= 2 && bus.m_axis_tvalid === 1'b1) begin
          stalled = 1'b1;
          tl = bus.m_axis_tlast;
          bus.m_axis_tready = 1'b0;
          for (int k = 0; k < 5; k++) begin
            #1;
            check("stall s_tready", 32'(bus.s_axis_tready), 32'd0);
            check("stall pipe_en",  32'(pipe_en),           32'd0);
            check("stall m_tvalid", 32'(bus.m_axis_tvalid), 32'd1);
            check("stall m_tlast",  32'(bus.m_axis_tlast),  32'(tl));
            tick();
          end
          bus.m_axis_tready = 1'b1;
        end
        bus.s_axis_tvalid = toggle ? tog : 1'b1;
        tog = !tog;
        bus.s_axis_tlast  = (n_acc == NPIX-1) && !bad_last;
        start = start_in_run && (ph == 1) && (n_acc == 7);
        tick();
        start = 1'b0;
      end
    end
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast  = 1'b0;
    check("frame completes within budget", 32'(finished), 32'd1);
    if (stall) check("stall applied", 32'(stalled), 32'd1);
  endtask

  task automatic frame_checks(input string tag);
    check({tag, " beats"},            32'(beats),                  32'd6);
    check({tag, " tlast count"},      32'(tlast_cnt),              32'd1);
    check({tag, " tlast on beat"},    32'(tlast_beat),             32'd6);
    check({tag, " done count"},       32'(done_cnt),               32'd1);
    check({tag, " done after tlast"}, 32'(done_cyc - last_hs_cyc), 32'd1);
    check({tag, " busy at tlast"},    32'(busy_at_hs),             32'd1);
    check({tag, " busy at done"},     32'(busy_at_done),           32'd0);
  endtask

  initial begin
    clear_stats();
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast  = 1'b0;
    bus.m_axis_tready = 1'b1;
    areset = 1'b1;
    tick();
    tick();
    check_all_zero("reset");
    areset = 1'b0;
    chk_en = 1'b1;
    tick();

    // Continuous frame: latency, beat count, TLAST placement, done timing.
    start_frame();
    run_frame(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    frame_checks("plain");
    check("plain latency px12", 32'(first_beat_cyc - acc12_cyc), 32'd2);
    check("plain win count",    32'(win_cnt),                    32'd6);
    check("plain frame_err",    32'(frame_err),                  32'd0);
    tick();

    // Output held for 5 cycles mid-frame.
    start_frame();
    run_frame(1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b0);
    frame_checks("stall");
    tick();

    // Input valid toggling each cycle.
    start_frame();
    run_frame(1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    check("toggle win count",    32'(win_cnt),    32'd6);
    check("toggle pipe_en runs", 32'(pe_run_cnt), 32'd20);
    check("toggle tlast count",  32'(tlast_cnt),  32'd1);
    check("toggle done count",   32'(done_cnt),   32'd1);
    tick();

    // Missing TLAST on the final pixel; the next start clears the flag.
    start_frame();
    run_frame(1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    frame_checks("badlast");
    check("badlast frame_err sticky", 32'(frame_err), 32'd1);
    tick();
    check("badlast frame_err idle", 32'(frame_err), 32'd1);
    start_frame();
    check("frame_err cleared by start", 32'(frame_err), 32'd0);
    run_frame(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    frame_checks("after badlast");
    tick();

    // Reset after 10 accepts, then a clean frame with no stale results.
    start_frame();
    run_frame(1'b0, 1'b0, 1'b0, 10, 1'b0, 1'b0);
    tick();
    start_frame();
    run_frame(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    frame_checks("post reset");
    tick();

    // start during RUN and during the DONE cycle must be ignored.
    start_frame();
    run_frame(1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b1);
    frame_checks("ignored start");
    bus.s_axis_tvalid = 1'b1;
    repeat (8) tick();
    check("no extra frame busy",  32'(busy),  32'd0);
    check("no extra frame beats", 32'(beats), 32'd6);
    bus.s_axis_tvalid = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/conv_frame_sequencer.md
Name: conv_frame_sequencer

Overview:
- Frame-level controller for the 3x3 convolution datapath on the AXI-Stream pixel path. It is software-started per frame and counts row and column over an IMG_W x IMG_H frame.
- Drives one global pipeline enable into the line buffers, window registers and MAC, plus the line-buffer column address and the window-valid flag.
- Carries valid/last tokens alongside the fixed-latency datapath so that only full-window results leave on the master stream, with exact TLAST and backpressure.
- Emits (IMG_W-2)*(IMG_H-2) results per frame.

Parameters:
- IMG_W, 128, pixels per row (>=3).
- IMG_H, 128, rows per frame (>=3).
- COL_W, 7, width of column counter/address (2**COL_W >= IMG_W).
- ROW_W, 7, width of row counter (2**ROW_W >= IMG_H).
- LAT, 4, datapath latency in pipe_en advances from pixel accept to result at output register (>=1).

Ports:
- aclk  in  1  clock, all logic on rising edge.
- areset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a frame (honoured only in IDLE).
- busy  out  1  high in RUN or DRAIN.
- done  out  1  one-cycle pulse after the frame's TLAST beat is accepted downstream.
- frame_err  out  1  sticky TLAST-mismatch flag; cleared by start or reset.
- s_axis_tvalid  in  1  input pixel valid.
- s_axis_tready  out  1  input pixel ready.
- s_axis_tlast  in  1  input end-of-frame marker (checked only, not used for counting).
- m_axis_tvalid  out  1  result valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  last result of frame.
- pipe_en  out  1  clock-enable for the whole datapath.
- lb_addr  out  COL_W  line-buffer column address (= current col).
- win_valid  out  1  the pixel accepted this cycle completes a full 3x3 window.

Behaviour:
- Reset values: state IDLE; col=0, row=0; token pipe cleared. All outputs 0: s_axis_tready, m_axis_tvalid, m_axis_tlast, pipe_en, busy, done, frame_err, lb_addr, win_valid.
- Reset mid-frame aborts immediately. In-flight tokens are discarded and no done pulse is produced.
- States:
  - IDLE: start -> RUN. Clears col, row and frame_err.
  - RUN: the accept of pixel (row=IMG_H-1, col=IMG_W-1) -> DRAIN.
  - DRAIN: the m_axis handshake with m_axis_tlast=1 -> DONE.
  - DONE: unconditional -> IDLE, with done=1 for this one cycle.
- start outside IDLE is ignored, including in the DONE cycle.
- adv = !m_axis_tvalid || m_axis_tready. This is stall-the-world: the datapath freezes whenever the output is held.
- s_axis_tready = (state==RUN) && adv. This is combinational; it does not depend on s_axis_tvalid.
- pipe_en:
  - RUN: s_axis_tvalid && s_axis_tready.
  - DRAIN: adv.
  - Otherwise: 0.
- Counters advance on RUN accepts only. Column runs 0..IMG_W-1, then wraps to 0 with row+1. Row stops at IMG_H-1; DRAIN is entered instead of wrapping.
- lb_addr = col (combinational from the counter).
- win_valid = accept && row>=2 && col>=2.
- Token pipe: depth LAT, entries {v,l}. On pipe_en:
  - tok[0] <= {win_valid, win_valid && row==IMG_H-1 && col==IMG_W-1}.
  - tok[i] <= tok[i-1].
  - In DRAIN, tok[0] <= {0,0}.
- Output flags: m_axis_tvalid = tok[LAT-1].v; m_axis_tlast = tok[LAT-1].v && tok[LAT-1].l. Both hold stable while m_axis_tvalid && !m_axis_tready.
- Latency: with continuous input and ready held high, a window-valid pixel accepted at cycle t appears as m_axis_tvalid at cycle t+LAT.
- Simultaneous accept and output handshake in the same cycle is legal; the pipe shifts once.
- frame_err is set on either mismatch at an accepted beat:
  - s_axis_tlast=1 when the beat is not the final pixel;
  - s_axis_tlast=0 on the final pixel.
- Counting continues by geometry regardless of frame_err.
- Beats offered while not in RUN are not accepted (s_axis_tready=0).

Test Plan:
- IMG_W=5, IMG_H=4, LAT=2; start, then 20 pixels with tvalid and m_axis_tready held 1:
  - exactly 6 m_axis_tvalid beats;
  - first beat 2 cycles after accepting pixel index 12 (row2,col2);
  - m_axis_tlast only on the 6th beat;
  - done pulses 1 cycle after it, and busy falls with done.
- Same frame with m_axis_tready=0 for 5 cycles while m_axis_tvalid=1:
  - s_axis_tready=0, pipe_en=0, and m_axis_tvalid/m_axis_tlast stable for those cycles;
  - the beat count is still 6.
- s_axis_tvalid toggling 1/0 each cycle: pipe_en pulses only on accepts, lb_addr follows 0..4 wrap, and win_valid is high for exactly 6 accepts.
- Final pixel sent with s_axis_tlast=0: frame_err=1 after that accept; 6 results and done still produced. The next start clears frame_err to 0.
- areset asserted after 10 accepts:
  - next cycle all outputs are 0 and state is IDLE;
  - a new start followed by 20 pixels yields exactly 6 results and no stale beats.
- start pulsed during RUN and during the DONE cycle: ignored, with no counter clear and no extra frame.
